// File: rtl/cholesky_seq.sv
`default_nettype none
// cholesky_seq: step sequencer for the cholesky datapath (sqrt/div/update per column).
// Rev 1.0
module cholesky_seq #(
  parameter int N        = 6,
  parameter int SQRT_LAT = 16,
  parameter int DIV_LAT  = 6,
  parameter int UPD_LAT  = 10,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_sqrt_nan,
  output logic [1:0] o_mode,
  output logic [2:0] o_column,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQRT = 3'd1,
    S_DIV  = 3'd2,
    S_UPD  = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_SQRT_LD  = CNT_W'(SQRT_LAT - 1);
  localparam logic [CNT_W-1:0] c_DIV_LD   = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] c_UPD_LD   = CNT_W'(UPD_LAT - 1);
  localparam logic [2:0]       c_LAST_COL = 3'(N - 1);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_col, w_col;
  logic             r_error, w_error;
  logic [1:0]       r_mode, w_mode;
  logic             r_busy, r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_col   <= '0;
      r_error <= 1'b0;
      r_mode  <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_col   <= w_col;
      r_error <= w_error;
      r_mode  <= w_mode;
      r_busy  <= (w_mode != 2'd0);
      r_done  <= (w_state == S_FIN);
    end
  end

  // Column register is forced to zero whenever a non-step state is entered.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_col   = r_col;
    w_error = r_error;
    w_mode  = 2'd0;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (i_start) begin
          w_state = S_SQRT;
          w_cnt   = c_SQRT_LD;
          w_col   = 3'd0;
          w_error = 1'b0;
        end
      end
      S_SQRT, S_DIV, S_UPD: begin
        if (i_abort) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_col   = 3'd0;
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          case (r_state)
            S_SQRT: begin
              if (i_sqrt_nan) begin
                w_state = S_ERR;
                w_error = 1'b1;
                w_col   = 3'd0;
              end else begin
                w_state = S_DIV;
                w_cnt   = c_DIV_LD;
              end
            end
            S_DIV: begin
              if (r_col == c_LAST_COL) begin
                w_state = S_FIN;
                w_col   = 3'd0;
              end else begin
                w_state = S_UPD;
                w_cnt   = c_UPD_LD;
              end
            end
            default: begin
              w_state = S_SQRT;
              w_cnt   = c_SQRT_LD;
              w_col   = r_col + 3'd1;
            end
          endcase
        end
      end
      S_FIN: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_col   = 3'd0;
      end
    endcase
    case (w_state)
      S_SQRT:  w_mode = 2'd1;
      S_DIV:   w_mode = 2'd2;
      S_UPD:   w_mode = 2'd3;
      default: w_mode = 2'd0;
    endcase
  end

  assign o_mode   = r_mode;
  assign o_column = r_col;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cholesky_seq.sv
`default_nettype none
// tb_cholesky_seq: randomized runs of cholesky_seq against a per-cycle schedule model.
// Rev 1.0
module tb_cholesky_seq;

  localparam int N = 6, S = 16, D = 6, U = 10;
  localparam int P = S + D + U;
  localparam int L = N * (S + D) + (N - 1) * U;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, nan = 1'b0;
  logic [1:0] mode;
  logic [2:0] column;
  logic       busy, done, error;

  logic       start2 = 1'b0;
  logic [1:0] mode2;
  logic [2:0] column2;
  logic       busy2, done2, error2;
  bit         saw_mode3 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cholesky_seq u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_sqrt_nan(nan),
    .o_mode(mode), .o_column(column), .o_busy(busy), .o_done(done), .o_error(error)
  );

  cholesky_seq #(.N(1), .SQRT_LAT(1), .DIV_LAT(1), .UPD_LAT(1), .CNT_W(5)) u_small (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .i_abort(1'b0), .i_sqrt_nan(1'b0),
    .o_mode(mode2), .o_column(column2), .o_busy(busy2), .o_done(done2), .o_error(error2)
  );

  always @(posedge clk) if (mode2 == 2'd3) saw_mode3 <= 1'b1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Mode of the i-th busy cycle (1-based) in an undisturbed run.
  function automatic int exp_mode(input int i);
    int r;
    r = (i - 1) % P;
    if (r < S) return 1;
    if (r < S + D) return 2;
    return 3;
  endfunction

  task automatic chk_all(input string tag, input int em, input int ec, input int eb,
                         input int ed, input int ee);
    chk({tag, ".mode"}, mode, em);
    chk({tag, ".column"}, column, ec);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".done"}, done, ed);
    chk({tag, ".error"}, error, ee);
  endtask

  // One factorisation: optional abort at cycle abort_at, optional NaN at the end of
  // column nan_col's sqrt step, optional start held high to chain a second run.
  task automatic run(input int abort_at, input int nan_col, input bit hold);
    int  nan_i, stop, last;
    bit  normal;
    int  em, ec, eb, ed, ee;
    nan_i  = (nan_col >= 0) ? nan_col * P + S : 0;
    stop   = L;
    normal = 1'b1;
    if (abort_at > 0) begin stop = abort_at; normal = 1'b0; end
    if (nan_i > 0)    begin stop = nan_i;    normal = 1'b0; end
    last = (hold && normal) ? L + 4 : stop + 3;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= last; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (i <= stop) begin
        em = exp_mode(i); ec = (i - 1) / P; eb = 1; ed = 0; ee = 0;
      end else if (i == stop + 1) begin
        em = 0; ec = 0; eb = 0; ed = normal ? 1 : 0; ee = (nan_i > 0) ? 1 : 0;
      end else if (hold && normal && i == L + 3) begin
        em = 1; ec = 0; eb = 1; ed = 0; ee = 0;
      end else begin
        em = 0; ec = 0; eb = 0; ed = 0; ee = (nan_i > 0) ? 1 : 0;
      end
      chk("run", em, em);
      n_checks--;
      chk_all("run", em, ec, eb, ed, ee);
      start = hold ? ((i < L + 3) ? 1'b1 : 1'b0) : ((i <= stop) ? 1'($urandom % 2) : 1'b0);
      abort = (i == abort_at) || (hold && i == L + 3) || (!hold && i > stop && ($urandom % 2) == 1);
      nan   = (i == nan_i) ||
              (!(exp_mode(i) == 1 && ((i - 1) % P) == S - 1) && ($urandom % 3) == 0);
    end
    start = 1'b0; abort = 1'b0; nan = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    chk("reset.small_mode", mode2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("idle", 0, 0, 0, 0, 0);

    run(0, -1, 1'b1);                                   // full run, start held, chained run
    run(0, 2, 1'b0);                                    // NaN at end of column 2 sqrt
    run(3 * P + S + 1 + int'($urandom % D), -1, 1'b0);  // abort during column 3 div
    run(0, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      k = int'($urandom % 3);
      if (k == 0)      run(1 + int'($urandom % L), -1, 1'b0);
      else if (k == 1) run(0, int'($urandom % N), 1'b0);
      else             run(0, -1, 1'b0);
    end

    // Asynchronous reset in the middle of column 0's update step.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 2; i <= 25; i++) begin
      @(posedge clk); #1;
      chk("pre_reset.mode", mode, exp_mode(i));
    end
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("held_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all("post_reset", 0, 0, 0, 0, 0);

    // Minimal configuration: one column, single-cycle steps.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("small.c1.mode", mode2, 1);
    chk("small.c1.busy", busy2, 1);
    @(posedge clk); #1;
    chk("small.c2.mode", mode2, 2);
    chk("small.c2.column", column2, 0);
    chk("small.c2.done", done2, 0);
    @(posedge clk); #1;
    chk("small.c3.done", done2, 1);
    chk("small.c3.mode", mode2, 0);
    chk("small.c3.busy", busy2, 0);
    @(posedge clk); #1;
    chk("small.c4.done", done2, 0);
    chk("small.no_mode3", saw_mode3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
